// File: rtl/ct_spsram_256x23_ctrl_if.sv
// Client-side bus for ct_spsram_256x23_ctrl: request port, read return and
// invalidate-all handshake. The client drives through the master modport;
// the controller receives through the slave modport.
interface ct_spsram_256x23_ctrl_if #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 23
);
  logic              inv_all_req;
  logic              inv_all_done;
  logic              req_vld;
  logic              req_rdy;
  logic              req_wr;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wbe;
  logic              rdata_vld;
  logic [DATA_W-1:0] rdata;
  logic              rdata_perr;

  modport master (
    output inv_all_req, req_vld, req_wr, req_idx, req_wdata, req_wbe,
    input  inv_all_done, req_rdy, rdata_vld, rdata, rdata_perr
  );

  modport slave (
    input  inv_all_req, req_vld, req_wr, req_idx, req_wdata, req_wbe,
    output inv_all_done, req_rdy, rdata_vld, rdata, rdata_perr
  );
endinterface

// File: rtl/ct_spsram_256x23_ctrl.sv
// Access controller for the 256x23 single-port tag/state SRAM.
// After reset (one idle WAIT cycle) and on every invalidate-all request it
// sweeps the whole array writing zeros, then serves a valid/ready client port
// with one-cycle read latency. Client enables are active high; SRAM controls
// are active low.
// Optional build macro CT_SPSRAM_256X23_PARITY_EN: bit 22 carries even parity
// over bits 21:0, every write is full-word and rdata_perr reports parity
// errors on returned reads. Without it bit 22 is plain data, req_wbe is
// honoured and rdata_perr is tied low.
module ct_spsram_256x23_ctrl #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 23
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  ct_spsram_256x23_ctrl_if.slave  cli,
  output logic [IDX_W-1:0]        sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_W-1:0]       sram_wen,
  output logic [DATA_W-1:0]       sram_d,
  input  logic [DATA_W-1:0]       sram_q
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_IDLE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
  logic              done_q, done_d;
  logic              rvld_q, rvld_d;
  logic              accept;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] wr_wen;

  assign cli.req_rdy = (state_q == ST_IDLE) & ~cli.inv_all_req;
  assign accept      = cli.req_vld & cli.req_rdy;
  assign rvld_d      = accept & ~cli.req_wr;

`ifdef CT_SPSRAM_256X23_PARITY_EN
  logic unused_wr_bits;

  // Top bit is replaced by even parity over the payload; writes are full-word.
  assign wr_data        = {^cli.req_wdata[DATA_W-2:0], cli.req_wdata[DATA_W-2:0]};
  assign wr_wen         = '0;
  assign unused_wr_bits = ^{cli.req_wbe, cli.req_wdata[DATA_W-1]};
  assign cli.rdata_perr = rvld_q & (^sram_q);
`else
  assign wr_data        = cli.req_wdata;
  assign wr_wen         = ~cli.req_wbe;
  assign cli.rdata_perr = 1'b0;
`endif

  assign cli.inv_all_done = done_q;
  assign cli.rdata_vld    = rvld_q;
  assign cli.rdata        = rvld_q ? sram_q : '0;

  // Next-state logic for the WAIT -> INIT sweep -> IDLE sequence.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
      ST_INIT: begin
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == '1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (cli.inv_all_req) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_WAIT;
        init_cnt_d = '0;
      end
    endcase
  end

  // SRAM pin drive: sweep writes zeros, otherwise an accepted request passes
  // straight through in the same cycle.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state_q == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
    end else if (accept) begin
      sram_cen  = 1'b0;
      sram_gwen = ~cli.req_wr;
      sram_a    = cli.req_idx;
      sram_d    = cli.req_wr ? wr_data : cli.req_wdata;
      sram_wen  = cli.req_wr ? wr_wen : '1;
    end
  end

  // State, sweep counter, completion pulse and read-valid registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_WAIT;
      init_cnt_q <= '0;
      done_q     <= 1'b0;
      rvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      done_q     <= done_d;
      rvld_q     <= rvld_d;
    end
  end

endmodule

// File: tb/tb_ct_spsram_256x23_ctrl.sv
// Bench for ct_spsram_256x23_ctrl: behavioural SRAM, a cycle-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_ct_spsram_256x23_ctrl;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 23;

`ifdef CT_SPSRAM_256X23_PARITY_EN
  localparam logic [22:0] EXP_5A = 23'h52345F;
`else
  localparam logic [22:0] EXP_5A = 23'h12345F;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [22:0] sram_wen, sram_d, sram_q;
  logic [22:0] ram [256];
  logic [22:0] q_reg;
  logic        q_force_en;
  logic [22:0] q_force_val;
  logic [22:0] m_mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ct_spsram_256x23_ctrl_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) cli ();

  ct_spsram_256x23_ctrl #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .cli            (cli),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Behavioural single-port SRAM with active-low controls and bit mask.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) ram[sram_a] <= (ram[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            q_reg <= ram[sram_a];
    end
  end
  assign sram_q = q_force_en ? q_force_val : q_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = post-reset idle, 1 = zeroing sweep, 2 = serving.
  initial begin : model
    int          phase, pos;
    bit          pend_done, pend_rvld;
    logic [22:0] rd_word, wrd;
    logic        e_cen, e_gwen, e_rdy, e_done, e_rvld, e_perr;
    logic [7:0]  e_a;
    logic [22:0] e_wen, e_d, e_rdata;
    phase = 0; pos = 0; pend_done = 0; pend_rvld = 0; rd_word = '0;
    forever begin
      @(negedge clk);
      e_cen = 1; e_gwen = 1; e_wen = '1; e_a = '0; e_d = '0;
      e_rdy = 0; e_done = 0; e_rvld = 0; e_rdata = '0; e_perr = 0;
      if (!rst_n) begin
        phase = 0; pend_done = 0; pend_rvld = 0;
      end else begin
        e_done = pend_done;
        e_rvld = pend_rvld;
        if (pend_rvld) e_rdata = q_force_en ? q_force_val : rd_word;
`ifdef CT_SPSRAM_256X23_PARITY_EN
        e_perr = pend_rvld & (^e_rdata);
`endif
        pend_done = 0;
        pend_rvld = 0;
        case (phase)
          0: begin phase = 1; pos = 0; end
          1: begin
            e_cen = 0; e_gwen = 0; e_wen = '0; e_a = 8'(pos);
            m_mem[pos] = '0;
            if (pos == 255) begin phase = 2; pend_done = 1; end
            else pos++;
          end
          default: begin
            e_rdy = !cli.inv_all_req;
            if (cli.inv_all_req) begin
              phase = 1; pos = 0;
            end else if (cli.req_vld) begin
              e_cen = 0; e_a = cli.req_idx; e_gwen = !cli.req_wr;
              if (cli.req_wr) begin
`ifdef CT_SPSRAM_256X23_PARITY_EN
                wrd = {^cli.req_wdata[21:0], cli.req_wdata[21:0]};
                e_wen = '0;
                m_mem[cli.req_idx] = wrd;
`else
                wrd = cli.req_wdata;
                e_wen = ~cli.req_wbe;
                m_mem[cli.req_idx] = (m_mem[cli.req_idx] & ~cli.req_wbe) | (wrd & cli.req_wbe);
`endif
                e_d = wrd;
              end else begin
                e_d = cli.req_wdata;
                rd_word = m_mem[cli.req_idx];
                pend_rvld = 1;
              end
            end
          end
        endcase
      end
      chk("sram_cen",     32'(sram_cen),          32'(e_cen));
      chk("sram_gwen",    32'(sram_gwen),         32'(e_gwen));
      chk("sram_wen",     32'(sram_wen),          32'(e_wen));
      chk("sram_a",       32'(sram_a),            32'(e_a));
      chk("sram_d",       32'(sram_d),            32'(e_d));
      chk("req_rdy",      32'(cli.req_rdy),       32'(e_rdy));
      chk("inv_all_done", 32'(cli.inv_all_done),  32'(e_done));
      chk("rdata_vld",    32'(cli.rdata_vld),     32'(e_rvld));
      chk("rdata",        32'(cli.rdata),         32'(e_rdata));
      chk("rdata_perr",   32'(cli.rdata_perr),    32'(e_perr));
    end
  end

  task automatic clr_req();
    cli.inv_all_req = 0; cli.req_vld = 0; cli.req_wr = 0;
    cli.req_idx = '0; cli.req_wdata = '0; cli.req_wbe = '0;
  endtask

  task automatic cyc_req(input logic vld, input logic wr, input logic [7:0] idx,
                         input logic [22:0] wd, input logic [22:0] wbe);
    cli.req_vld = vld; cli.req_wr = wr; cli.req_idx = idx;
    cli.req_wdata = wd; cli.req_wbe = wbe;
    @(posedge clk); #1;
  endtask

  task automatic rd_check(input string name, input logic [7:0] idx, input logic [22:0] exp);
    cyc_req(1, 0, idx, '0, '0);
    clr_req();
    @(negedge clk);
    chk({name, "_vld"},  32'(cli.rdata_vld),  32'd1);
    chk({name, "_data"}, 32'(cli.rdata),      32'(exp));
    chk({name, "_perr"}, 32'(cli.rdata_perr), 32'd0);
    @(posedge clk); #1;
  endtask

  // Called at +1 into the cycle before the first sweep write (WAIT or the
  // cycle holding inv_all_req); returns at +1 into the cycle after done.
  task automatic sweep_check(input string tag);
    @(negedge clk);
    chk({tag, "_pre_cen"}, 32'(sram_cen),    32'd1);
    chk({tag, "_pre_rdy"}, 32'(cli.req_rdy), 32'd0);
    @(posedge clk); #1;
    clr_req();
    @(negedge clk);
    chk({tag, "_first_a"},   32'(sram_a),    32'd0);
    chk({tag, "_first_cen"}, 32'(sram_cen),  32'd0);
    chk({tag, "_first_wen"}, 32'(sram_wen),  32'd0);
    repeat (254) @(negedge clk);
    @(negedge clk);
    chk({tag, "_last_a"},    32'(sram_a),          32'd255);
    chk({tag, "_last_rdy"},  32'(cli.req_rdy),     32'd0);
    chk({tag, "_last_done"}, 32'(cli.inv_all_done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(cli.inv_all_done), 32'd1);
    chk({tag, "_rdy"},  32'(cli.req_rdy),      32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [22:0] pat;
    rst_n = 0; q_force_en = 0; q_force_val = '0;
    clr_req();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cen",  32'(sram_cen),         32'd1);
    chk("rst_wen",  32'(sram_wen),         32'h7FFFFF);
    chk("rst_rdy",  32'(cli.req_rdy),      32'd0);
    chk("rst_rvld", 32'(cli.rdata_vld),    32'd0);
    rst_n = 1;
    sweep_check("init");

    // Write then read the same index on the next cycle.
    cyc_req(1, 1, 8'h5A, 23'h12345F, '1);
    rd_check("wr_rd_5a", 8'h5A, EXP_5A);

`ifdef CT_SPSRAM_256X23_PARITY_EN
    cli.req_vld = 1; cli.req_wr = 1; cli.req_idx = 8'd9;
    cli.req_wdata = 23'h000001; cli.req_wbe = '0;
    #1;
    chk("par_d",   32'(sram_d),   32'h400001);
    chk("par_wen", 32'(sram_wen), 32'd0);
    @(posedge clk); #1;
    cyc_req(1, 0, 8'd9, '0, '0);
    clr_req();
    q_force_val = 23'h000001; q_force_en = 1;
    @(negedge clk);
    chk("par_forced_perr", 32'(cli.rdata_perr), 32'd1);
    @(posedge clk); #1;
    q_force_en = 0;
    rd_check("par_rd9", 8'd9, 23'h400001);
`else
    cyc_req(1, 1, 8'd3, 23'h7FFFFF, '1);
    cyc_req(1, 1, 8'd3, 23'h000000, 23'h0000FF);
    rd_check("partial", 8'd3, 23'h7FFF00);
`endif

    // Back-to-back writes then back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      pat = 23'h0F0F0F ^ 23'(i * 32'h11111);
      cyc_req(1, 1, 8'(8'h10 + i), pat, '1);
    end
    for (int i = 0; i < 8; i++) cyc_req(1, 0, 8'(8'h10 + i), '0, '0);
    clr_req();
    cyc_req(0, 0, '0, '0, '0);

    // Invalidate wins over a simultaneous request.
    cli.inv_all_req = 1;
    cli.req_vld = 1; cli.req_wr = 1; cli.req_idx = 8'h20;
    cli.req_wdata = 23'h7AAAAA; cli.req_wbe = '1;
    sweep_check("inv");
    rd_check("after_inv_5a", 8'h5A, 23'h000000);
    rd_check("after_inv_20", 8'h20, 23'h000000);

    // Reset while a read response is pending.
    cyc_req(1, 1, 8'h11, 23'h0ABCDE, '1);
    cyc_req(1, 0, 8'h11, '0, '0);
    clr_req();
    chk("mid_rd_vld", 32'(cli.rdata_vld), 32'd1);
    rst_n = 0;
    #1;
    chk("mid_rd_drop", 32'(cli.rdata_vld), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    sweep_check("rst_rd");

    // Reset in the middle of the sweep at index 100.
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (101) @(posedge clk);
    #1;
    chk("mid_sweep_a",   32'(sram_a),   32'd100);
    chk("mid_sweep_cen", 32'(sram_cen), 32'd0);
    rst_n = 0;
    #1;
    chk("rst_sweep_cen", 32'(sram_cen),  32'd1);
    chk("rst_sweep_a",   32'(sram_a),    32'd0);
    chk("rst_sweep_wen", 32'(sram_wen),  32'h7FFFFF);
    @(posedge clk); #1;
    rst_n = 1;
    sweep_check("rst_sweep");
    rd_check("after_rst_11", 8'h11, 23'h000000);

    repeat (3) cyc_req(0, 0, '0, '0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
